// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, the reset/flush NOP, ALUOp classes
// and the control bundle produced by the decoder.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          REG_COUNT = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } aluop_t;

    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   alu_src;
        logic   branch;
        aluop_t alu_op;
    } ctrl_t;

    // Only R, S and B formats carry a real rs2; elsewhere bits [24:20] are
    // immediate or shamt bits and must not raise a load-use hazard.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file: two combinational read ports, one write port,
// synchronous reset, x0 hard-wired to zero, write-through on same-cycle reads.
module register_file
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [REG_COUNT];
    logic        write_en;

    assign write_en = we && (rd_addr != 5'd0) && !reset;

    // Clear on reset; otherwise commit the writeback (x0 never written).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[rd_addr] <= wdata;
        end
    end

    // Reads bypass the array when the same register is being written this cycle.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (write_en && (rd_addr == rs1_addr)) rs1_data = wdata;
        if (write_en && (rd_addr == rs2_addr)) rs2_data = wdata;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register with flush/stall, register file,
// immediate generation, main control decode and load-use hazard detection.
module id_stage
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_IF,
    input  logic [31:0] INSTRUCTION_IF,
    input  logic        PCSrc,
    input  logic        MemRead_EX,
    input  logic [4:0]  RD_EX,
    input  logic        RegWrite_WB,
    input  logic [4:0]  RD_WB,
    input  logic [31:0] WB_DATA,
    output logic        PC_write,
    output logic [31:0] PC_ID,
    output logic [31:0] INSTRUCTION_ID,
    output logic [31:0] RS1_DATA,
    output logic [31:0] RS2_DATA,
    output logic [31:0] IMM_ID,
    output logic [4:0]  RS1_ID,
    output logic [4:0]  RS2_ID,
    output logic [4:0]  RD_ID,
    output logic [2:0]  FUNCT3_ID,
    output logic [6:0]  FUNCT7_ID,
    output logic        RegWrite_ID,
    output logic        MemRead_ID,
    output logic        MemWrite_ID,
    output logic        MemtoReg_ID,
    output logic        ALUSrc_ID,
    output logic        Branch_ID,
    output logic [1:0]  ALUOp_ID
);

    logic [6:0]  opcode;
    logic        stall;
    ctrl_t       ctrl;
    logic [31:0] instr;

    assign instr     = INSTRUCTION_ID;
    assign opcode    = instr[6:0];
    assign RD_ID     = instr[11:7];
    assign FUNCT3_ID = instr[14:12];
    assign RS1_ID    = instr[19:15];
    assign RS2_ID    = instr[24:20];
    assign FUNCT7_ID = instr[31:25];

    // IF/ID register: reset, then flush (beats stall), then hold on stall.
    always_ff @(posedge clk) begin
        if (reset || PCSrc) begin
            PC_ID          <= '0;
            INSTRUCTION_ID <= NOP_INSTR;
        end else if (!stall) begin
            PC_ID          <= PC_IF;
            INSTRUCTION_ID <= INSTRUCTION_IF;
        end
    end

    // Load-use hazard against the load currently in EX.
    always_comb begin
        stall = MemRead_EX && (RD_EX != 5'd0) &&
                ((RD_EX == RS1_ID) || (uses_rs2(opcode) && (RD_EX == RS2_ID)));
    end

    assign PC_write = !stall;

    // Main control decode; a stall turns the instruction into a bubble.
    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OP_R:      begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALUOP_FUNCT; end
            OP_IMM:    begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_FUNCT; end
            OP_LOAD:   begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_STORE:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; end
            OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_op = ALUOP_BRANCH; end
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (stall) ctrl = '0;
    end

    assign RegWrite_ID = ctrl.reg_write;
    assign MemRead_ID  = ctrl.mem_read;
    assign MemWrite_ID = ctrl.mem_write;
    assign MemtoReg_ID = ctrl.mem_to_reg;
    assign ALUSrc_ID   = ctrl.alu_src;
    assign Branch_ID   = ctrl.branch;
    assign ALUOp_ID    = ctrl.alu_op;

    // Immediate generation, sign-extended from instr[31].
    always_comb begin
        IMM_ID = '0;
        unique case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: IMM_ID = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 IMM_ID = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                IMM_ID = {{19{instr[31]}}, instr[31], instr[7],
                                                instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         IMM_ID = {instr[31:12], 12'b0};
            OP_JAL:                   IMM_ID = {{11{instr[31]}}, instr[31], instr[19:12],
                                                instr[20], instr[30:21], 1'b0};
            default:                  IMM_ID = '0;
        endcase
    end

    register_file u_register_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (RS1_ID),
        .rs2_addr (RS2_ID),
        .rs1_data (RS1_DATA),
        .rs2_data (RS2_DATA),
        .we       (RegWrite_WB),
        .rd_addr  (RD_WB),
        .wdata    (WB_DATA)
    );

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage RISC-V (RV32I) pipeline; consumes PC_IF/INSTRUCTION_IF from the fetch stage and feeds EX.
- Contains the IF/ID pipeline register with stall and flush, the 32x32 register file, immediate generation, main control decode and load-use hazard detection.
- Drives PC_write back to fetch so that a load-use hazard freezes the PC.

Parameters:
- NOP_INSTR, 32'h00000013, instruction loaded on reset and flush (addi x0,x0,0).
- REG_COUNT, 32, number of architectural registers. Fixed for RV32I.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- PC_IF  in  32  PC of the instruction being fetched.
- INSTRUCTION_IF  in  32  fetched instruction.
- PCSrc  in  1  branch taken in EX. Flushes IF/ID.
- MemRead_EX  in  1  instruction in EX is a load.
- RD_EX  in  5  destination register of the instruction in EX.
- RegWrite_WB  in  1  writeback enable.
- RD_WB  in  5  writeback destination register.
- WB_DATA  in  32  writeback data.
- PC_write  out  1  fetch PC enable; 0 during a stall.
- PC_ID, INSTRUCTION_ID  out  32 each  registered IF/ID contents.
- RS1_DATA, RS2_DATA  out  32 each  register file read data.
- IMM_ID  out  32  sign-extended immediate.
- RS1_ID, RS2_ID, RD_ID  out  5 each  register fields.
- FUNCT3_ID  out  3  funct3 field.
- FUNCT7_ID  out  7  funct7 field.
- RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID  out  1 each  control signals.
- ALUOp_ID  out  2  ALU operation class.

Behaviour:
- IF/ID register update, on posedge, in priority order:
  - reset: PC_ID=0, INSTRUCTION_ID=NOP_INSTR.
  - PCSrc: PC_ID=0, INSTRUCTION_ID=NOP_INSTR. Flush wins over stall.
  - stall: hold both values.
  - otherwise: load PC_IF and INSTRUCTION_IF.
- Hazard detection (combinational):
  - stall = MemRead_EX && RD_EX!=0 && (RD_EX==rs1 || (uses_rs2 && RD_EX==rs2)).
  - uses_rs2 is true for R, S and B formats only.
  - PC_write = !stall.
- Stall bubble: while stall is high, all control outputs are forced to 0 and ALUOp_ID=00. Data and field outputs pass through unchanged.
- Register file:
  - Write on posedge when RegWrite_WB && RD_WB!=0.
  - Reads are combinational; x0 always reads 0.
  - Write-through: a read of RD_WB in the same cycle as its write returns WB_DATA.
  - reset clears all registers to 0 on the same edge. Writeback in the reset cycle is ignored.
- Immediate by opcode, all sign-extended from the top instruction bit:
  - I-format (0010011, 0000011, 1100111): bits[31:20].
  - S-format (0100011): {[31:25],[11:7]}.
  - B-format (1100011): {[31],[7],[30:25],[11:8],0}.
  - U-format (0110111, 0010111): {[31:12],12'b0}.
  - J-format (1101111): {[31],[19:12],[20],[30:21],0}.
  - Any other opcode: 0.
- Control decode (signals not listed are 0):
  - R (0110011): RegWrite, ALUOp=10.
  - I-ALU (0010011): RegWrite, ALUSrc, ALUOp=10.
  - Load (0000011): RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00.
  - Store (0100011): MemWrite, ALUSrc, ALUOp=00.
  - Branch (1100011): Branch, ALUOp=01.
  - LUI/AUIPC/JAL/JALR: RegWrite, ALUSrc, ALUOp=00.
  - Unknown opcode: all 0.
- Latency: one cycle from INSTRUCTION_IF to INSTRUCTION_ID. All decode outputs are combinational from the IF/ID register.
- After reset, the NOP in ID produces no hazard, so PC_write=1.

Decomposition:
- Shared package rv_pkg:
  - opcode constants.
  - NOP_INSTR.
  - ALUOp encodings (00 add, 01 branch, 10 funct-decoded).
- Sub-module register_file: 2 read ports, 1 write port, synchronous reset, write-through.
- Decode, immediate generation and hazard logic stay in id_stage.

Test Plan:
1. Load pipeline, then pulse reset mid-stream. Next cycle: INSTRUCTION_ID=0x00000013, PC_ID=0, all RS*_DATA=0, PC_write=1.
2. Write path:
   - RegWrite_WB=1, RD_WB=5, WB_DATA=0xDEADBEEF, with ID holding add x1,x5,x0: RS1_DATA=0xDEADBEEF in the same cycle (write-through).
   - Same stimulus with RD_WB=0: x0 still reads 0.
3. Load-use hazard: MemRead_EX=1, RD_EX=3, ID holds add x4,x3,x2:
   - PC_write=0, RegWrite_ID=0, INSTRUCTION_ID held next cycle.
   - With RD_EX=0 instead: no stall.
4. Flush: PCSrc=1 together with a stall. Next cycle INSTRUCTION_ID=NOP_INSTR (flush wins).
5. Immediates:
   - sw x2,-4(x1) (0xFE20AE23): IMM_ID=0xFFFFFFFC, MemWrite_ID=1.
   - beq offset -8 (0xFE000CE3): IMM_ID=0xFFFFFFF8, Branch_ID=1, ALUOp_ID=01.
6. lui x7,0x12345 (0x123453B7): IMM_ID=0x12345000, RD_ID=7, RegWrite_ID=1, ALUSrc_ID=1.
